cbd_poly_writer: RTL

- Downstream consumer of the CBD sampler (eta=2, Kyber-768-90s).
- Accepts a stream of 256 signed noise coefficients and maps each into [0,q).
- Writes each mapped coefficient into the polynomial RAM at its index.
- Mode select: overwrite the RAM contents (fresh s/e vectors) or add mod q into them (e.g. adding e to A·s during keygen/encrypt).

---
 rtl/cbd_poly_writer_if.sv | 33 +++
 rtl/cbd_poly_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cbd_poly_writer_if.sv
// Bundles the sample stream, polynomial RAM ports and status flags of cbd_poly_writer.
// The slave modport is the writer itself; master is whoever drives samples and owns the RAM.
interface cbd_poly_writer_if #(
    parameter int COEFF_W = 12,
    parameter int ADDR_W  = 8
);
    logic               start;
    logic               accumulate;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_coeff;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [COEFF_W-1:0] mem_rdata;
    logic               mem_wr_en;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [COEFF_W-1:0] mem_wdata;
    logic               busy;
    logic               done;
    logic               err;

    modport slave (
        input  start, accumulate, in_valid, in_coeff, mem_rdata,
        output in_ready, mem_rd_en, mem_raddr, mem_wr_en, mem_waddr, mem_wdata,
        output busy, done, err
    );

    modport master (
        output start, accumulate, in_valid, in_coeff, mem_rdata,
        input  in_ready, mem_rd_en, mem_raddr, mem_wr_en, mem_waddr, mem_wdata,
        input  busy, done, err
    );
endinterface

// File: rtl/cbd_poly_writer.sv
// Maps a stream of 256 signed CBD samples into [0,q) and writes (or adds mod q) them
// into the polynomial RAM through a fixed two-stage read/add/write pipeline.
module cbd_poly_writer #(
    parameter int Q       = 3329,
    parameter int N       = 256,
    parameter int COEFF_W = 12,
    parameter int ETA     = 2,
    parameter int ADDR_W  = 8
) (
    input logic              clk,
    input logic              reset,
    cbd_poly_writer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [COEFF_W:0]  Q_WIDE = (COEFF_W + 1)'(Q);
    localparam logic [ADDR_W:0]   LAST_K = (ADDR_W + 1)'(N - 1);

    state_t state;
    state_t state_next;

    logic [ADDR_W:0]    count;
    logic               acc_mode;
    logic               err_flag;
    logic               accept;
    logic               start_ok;
    logic signed [2:0]  coeff;
    logic               illegal;
    logic [COEFF_W-1:0] mapped;

    logic               a_valid;
    logic [ADDR_W-1:0]  a_addr;
    logic [COEFF_W-1:0] a_w;
    logic               b_valid;
    logic [ADDR_W-1:0]  b_addr;
    logic [COEFF_W-1:0] b_data;

    logic [COEFF_W:0]   sum;
    logic [COEFF_W-1:0] result;

    assign coeff    = bus.in_coeff;
    assign accept   = bus.in_valid & bus.in_ready;
    assign start_ok = bus.start & (state == IDLE);

    assign illegal = (coeff > ETA) || (coeff < -ETA);

    always_comb begin
        mapped = '0;
        if (!illegal) begin
            if (coeff < 0)
                mapped = COEFF_W'(Q + int'(coeff));
            else
                mapped = COEFF_W'(int'(coeff));
        end
    end

    // RAM data arrives one cycle after the read issued at acceptance; a single
    // conditional subtraction suffices because both operands are below q.
    always_comb begin
        sum    = {1'b0, bus.mem_rdata} + {1'b0, a_w};
        result = a_w;
        if (acc_mode) begin
            if (sum >= Q_WIDE)
                result = COEFF_W'(sum - Q_WIDE);
            else
                result = sum[COEFF_W-1:0];
        end
    end

    assign bus.mem_rd_en = accept & acc_mode;
    assign bus.mem_raddr = bus.mem_rd_en ? count[ADDR_W-1:0] : '0;
    assign bus.mem_wr_en = b_valid;
    assign bus.mem_waddr = b_addr;
    assign bus.mem_wdata = b_data;
    assign bus.err       = err_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // In DRAIN no new samples enter, so once stage A is empty the only pending
    // write is the one being performed this cycle and done can follow next cycle.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = RUN;
            end
            RUN: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (accept && (count == LAST_K))
                    state_next = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (!a_valid)
                    state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc_mode <= 1'b0;
            err_flag <= 1'b0;
        end else if (start_ok) begin
            count    <= '0;
            acc_mode <= bus.accumulate;
            err_flag <= 1'b0;
        end else if (accept) begin
            count <= count + 1'b1;
            if (illegal)
                err_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
            a_w     <= '0;
            b_valid <= 1'b0;
            b_addr  <= '0;
            b_data  <= '0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_addr <= count[ADDR_W-1:0];
                a_w    <= mapped;
            end
            b_valid <= a_valid;
            if (a_valid) begin
                b_addr <= a_addr;
                b_data <= result;
            end
        end
    end

endmodule
